// File: rtl/rx_block_assembler.sv
// rx_block_assembler: packs a serial byte stream into 128-bit key or data blocks.
// The first byte received lands in bits [127:120].
// A complete key block is published on rx_key together with a one-cycle key_load pulse.
// A complete data block is presented on blk_data under a blk_valid/blk_ready handshake.
// A block is discarded if its key/data flag changes mid-block, or if it stalls too long.
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset
//   in_byte/in_valid  incoming byte stream; in_is_key marks key bytes, in_ready accepts
//   key_load, rx_key  one-cycle pulse when rx_key holds a newly completed key
//   blk_valid/ready   data block handshake; blk_data holds the block
//   frame_err         one-cycle pulse when a partial block is discarded
//   byte_cnt          number of bytes held in the current partial block
module rx_block_assembler #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic [7:0]   in_byte,
   input  logic         in_valid,
   input  logic         in_is_key,
   output logic         in_ready,
   output logic         key_load,
   output logic [127:0] rx_key,
   output logic         blk_valid,
   output logic [127:0] blk_data,
   input  logic         blk_ready,
   output logic         frame_err,
   output logic [4:0]   byte_cnt
);

   localparam int unsigned BLK_W  = 128;
   localparam int unsigned BYTES  = 16;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILL    = 2'd1,
      KEY_OUT = 2'd2,
      BLK_OUT = 2'd3
   } state_t;

   state_t             state_q;
   logic [BLK_W-1:0]   sr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               kind_q;
   logic [TO_W-1:0]    idle_q;
   logic               in_ready_q;
   logic               key_load_q;
   logic [BLK_W-1:0]   rx_key_q;
   logic               blk_valid_q;
   logic [BLK_W-1:0]   blk_data_q;
   logic               frame_err_q;

   // Shift register contents including the byte being accepted this cycle.
   logic [BLK_W-1:0]   sr_d;
   logic               accept_c;
   logic               last_byte_c;
   logic               timeout_c;

   assign sr_d        = {sr_q[BLK_W-9:0], in_byte};
   assign accept_c    = in_valid & in_ready_q;
   assign last_byte_c = (cnt_q == CNT_W'(BYTES - 1));
   assign timeout_c   = (TIMEOUT_CYCLES != 0) && (idle_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Assembler FSM with registered outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         kind_q      <= 1'b0;
         idle_q      <= '0;
         in_ready_q  <= 1'b1;
         key_load_q  <= 1'b0;
         rx_key_q    <= '0;
         blk_valid_q <= 1'b0;
         blk_data_q  <= '0;
         frame_err_q <= 1'b0;
      end else begin
         key_load_q  <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               idle_q <= '0;
               if (accept_c) begin
                  sr_q    <= BLK_W'(in_byte);
                  cnt_q   <= CNT_W'(1);
                  kind_q  <= in_is_key;
                  state_q <= FILL;
               end
            end
            FILL: begin
               if (accept_c) begin
                  idle_q <= '0;
                  // A flag change restarts the block with the offending byte, before any completion.
                  if (in_is_key != kind_q) begin
                     frame_err_q <= 1'b1;
                     sr_q        <= BLK_W'(in_byte);
                     cnt_q       <= CNT_W'(1);
                     kind_q      <= in_is_key;
                  end else if (last_byte_c) begin
                     cnt_q      <= '0;
                     in_ready_q <= 1'b0;
                     if (kind_q) begin
                        rx_key_q   <= sr_d;
                        key_load_q <= 1'b1;
                        state_q    <= KEY_OUT;
                     end else begin
                        blk_data_q  <= sr_d;
                        blk_valid_q <= 1'b1;
                        state_q     <= BLK_OUT;
                     end
                  end else begin
                     sr_q  <= sr_d;
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end else if (timeout_c) begin
                  frame_err_q <= 1'b1;
                  cnt_q       <= '0;
                  idle_q      <= '0;
                  state_q     <= IDLE;
               end else if (TIMEOUT_CYCLES != 0) begin
                  idle_q <= idle_q + TO_W'(1);
               end
            end
            KEY_OUT: begin
               // Single bubble cycle so key and data output never overlap.
               in_ready_q <= 1'b1;
               state_q    <= IDLE;
            end
            BLK_OUT: begin
               if (blk_ready) begin
                  blk_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign key_load  = key_load_q;
   assign rx_key    = rx_key_q;
   assign blk_valid = blk_valid_q;
   assign blk_data  = blk_data_q;
   assign frame_err = frame_err_q;
   assign byte_cnt  = cnt_q;

endmodule

// File: tb/tb_rx_block_assembler.sv
// Testbench for rx_block_assembler: directed and random stimulus with a queue-based scoreboard.
module tb_rx_block_assembler;

   logic         clk;
   logic         n_rst;
   logic [7:0]   in_byte;
   logic         in_valid;
   logic         in_is_key;
   logic         in_ready;
   logic         key_load;
   logic [127:0] rx_key;
   logic         blk_valid;
   logic [127:0] blk_data;
   logic         blk_ready;
   logic         frame_err;
   logic [4:0]   byte_cnt;

   logic         rdy_dir;
   logic         rdy_rnd;
   logic         rnd_mode;

   int checks = 0;
   int errors = 0;
   int ferr_exp = 0;
   int ferr_seen = 0;

   logic [127:0] exp_key[$];
   logic [127:0] exp_blk[$];

   assign blk_ready = rnd_mode ? rdy_rnd : rdy_dir;

   rx_block_assembler #(.TIMEOUT_CYCLES(8)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .in_byte   (in_byte),
      .in_valid  (in_valid),
      .in_is_key (in_is_key),
      .in_ready  (in_ready),
      .key_load  (key_load),
      .rx_key    (rx_key),
      .blk_valid (blk_valid),
      .blk_data  (blk_data),
      .blk_ready (blk_ready),
      .frame_err (frame_err),
      .byte_cnt  (byte_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_w(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic chk_b(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b", nm, act, exp);
      end
   endtask

   // Present one byte from a negedge; returns at the negedge after it was accepted.
   task automatic send_byte(input logic [7:0] b, input logic k);
      int guard = 0;
      in_byte   = b;
      in_is_key = k;
      in_valid  = 1'b1;
      while (!in_ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         errors++;
         $display("FAIL send_wait actual=in_ready_low required=in_ready_high");
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_block(input logic k, input logic [127:0] d, input int gap_max);
      for (int i = 0; i < 16; i++) begin
         send_byte(d[127-8*i -: 8], k);
         if (gap_max > 0 && i < 15) idle(int'($urandom_range(0, gap_max)));
      end
   endtask

   // Random downstream backpressure.
   initial begin
      rdy_rnd = 1'b0;
      forever begin
         @(negedge clk);
         rdy_rnd = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: compares DUT output events against the expected queues.
   initial begin
      logic [127:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (n_rst) begin
            if (key_load) begin
               if (exp_key.size() == 0) begin
                  errors++;
                  $display("FAIL key_unexpected actual=%h expected=no_key_load", rx_key);
               end else begin
                  e = exp_key.pop_front();
                  chk_w("rx_key", rx_key, e);
               end
            end
            if (blk_valid) begin
               if (exp_blk.size() == 0) begin
                  errors++;
                  $display("FAIL blk_unexpected actual=%h expected=no_blk_valid", blk_data);
               end else begin
                  chk_w("blk_data", blk_data, exp_blk[0]);
                  if (blk_ready) e = exp_blk.pop_front();
               end
            end
            if (frame_err) ferr_seen++;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // Stimulus.
   initial begin
      logic [127:0] blk;
      int guard;
      n_rst = 1'b0; in_byte = '0; in_valid = 1'b0; in_is_key = 1'b0;
      rdy_dir = 1'b1; rnd_mode = 1'b0;
      repeat (3) @(negedge clk);
      chk_b("rst_blk_valid", blk_valid, 1'b0);
      n_rst = 1'b1;
      @(negedge clk);
      chk_b("rst_in_ready", in_ready, 1'b1);
      chk_b("rst_key_load", key_load, 1'b0);
      chk_b("rst_frame_err", frame_err, 1'b0);
      chk_w("rst_byte_cnt", 128'(byte_cnt), 128'(0));
      chk_w("rst_rx_key", rx_key, 128'(0));
      chk_w("rst_blk_data", blk_data, 128'(0));

      // Key block 00..0F back-to-back.
      exp_key.push_back(128'h000102030405060708090A0B0C0D0E0F);
      send_block(1'b1, 128'h000102030405060708090A0B0C0D0E0F, 0);
      chk_b("key_pulse", key_load, 1'b1);
      chk_b("key_in_ready_low", in_ready, 1'b0);
      chk_w("key_byte_cnt", 128'(byte_cnt), 128'(0));
      @(negedge clk);
      chk_b("key_pulse_end", key_load, 1'b0);
      chk_b("key_in_ready_back", in_ready, 1'b1);

      // Data block F0..FF held by backpressure for 5 cycles.
      rdy_dir = 1'b0;
      exp_blk.push_back(128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
      send_block(1'b0, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF, 0);
      for (int i = 0; i < 5; i++) begin
         chk_b("hold_blk_valid", blk_valid, 1'b1);
         chk_b("hold_in_ready", in_ready, 1'b0);
         @(negedge clk);
      end
      rdy_dir = 1'b1;
      @(negedge clk);
      chk_b("release_blk_valid", blk_valid, 1'b0);
      chk_b("release_in_ready", in_ready, 1'b1);
      chk_w("key_held", rx_key, 128'h000102030405060708090A0B0C0D0E0F);

      // 7 key bytes then a data byte: framing error, data block restarts.
      for (int i = 0; i < 7; i++) send_byte(8'(8'h10 + i), 1'b1);
      chk_w("partial_cnt7", 128'(byte_cnt), 128'(7));
      exp_blk.push_back(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
      ferr_exp++;
      send_byte(8'hA0, 1'b0);
      chk_b("mismatch_frame_err", frame_err, 1'b1);
      chk_w("mismatch_cnt1", 128'(byte_cnt), 128'(1));
      for (int i = 1; i < 16; i++) send_byte(8'(8'hA0 + i), 1'b0);
      chk_b("mismatch_blk_valid", blk_valid, 1'b1);
      chk_b("mismatch_no_key", key_load, 1'b0);
      idle(3);

      // Timeout after 8 idle cycles.
      for (int i = 0; i < 3; i++) send_byte(8'(8'h20 + i), 1'b0);
      idle(7);
      chk_b("to_not_yet", frame_err, 1'b0);
      chk_w("to_cnt_held", 128'(byte_cnt), 128'(3));
      ferr_exp++;
      idle(1);
      chk_b("to_frame_err", frame_err, 1'b1);
      chk_w("to_cnt0", 128'(byte_cnt), 128'(0));
      idle(1);
      chk_b("to_pulse_end", frame_err, 1'b0);

      // A byte on the 8th idle cycle prevents the timeout.
      exp_blk.push_back(128'h303132333435363738393A3B3C3D3E3F);
      for (int i = 0; i < 3; i++) send_byte(8'(8'h30 + i), 1'b0);
      idle(7);
      send_byte(8'h33, 1'b0);
      chk_b("to_prevented", frame_err, 1'b0);
      chk_w("to_prevented_cnt", 128'(byte_cnt), 128'(4));
      for (int i = 4; i < 16; i++) send_byte(8'(8'h30 + i), 1'b0);
      idle(3);

      // Reset with blk_valid high.
      rdy_dir = 1'b0;
      exp_blk.push_back(128'h505152535455565758595A5B5C5D5E5F);
      send_block(1'b0, 128'h505152535455565758595A5B5C5D5E5F, 0);
      chk_b("pre_rst_valid", blk_valid, 1'b1);
      #2 n_rst = 1'b0;
      #1;
      chk_b("arst_blk_valid", blk_valid, 1'b0);
      chk_b("arst_key_load", key_load, 1'b0);
      chk_w("arst_rx_key", rx_key, 128'(0));
      chk_w("arst_blk_data", blk_data, 128'(0));
      exp_blk.delete();
      @(negedge clk);
      n_rst = 1'b1;
      rdy_dir = 1'b1;

      // Reset with 10 bytes held.
      for (int i = 0; i < 10; i++) send_byte(8'(8'h70 + i), 1'b1);
      chk_w("held10", 128'(byte_cnt), 128'(10));
      #2 n_rst = 1'b0;
      #1;
      chk_w("arst_cnt", 128'(byte_cnt), 128'(0));
      chk_b("arst_frame_err", frame_err, 1'b0);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      exp_key.push_back(128'h606162636465666768696A6B6C6D6E6F);
      send_block(1'b1, 128'h606162636465666768696A6B6C6D6E6F, 0);
      chk_b("fresh_key_pulse", key_load, 1'b1);
      idle(2);

      // Random blocks with gaps and backpressure.
      rnd_mode = 1'b1;
      for (int b = 0; b < 200; b++) begin
         logic k;
         k   = 1'($urandom_range(0, 1));
         blk = {$urandom, $urandom, $urandom, $urandom};
         if (k) exp_key.push_back(blk);
         else   exp_blk.push_back(blk);
         send_block(k, blk, 3);
      end
      guard = 0;
      while ((exp_key.size() != 0 || exp_blk.size() != 0) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      rnd_mode = 1'b0;
      idle(3);
      chk_w("keys_drained", 128'(exp_key.size()), 128'(0));
      chk_w("blks_drained", 128'(exp_blk.size()), 128'(0));
      chk_w("frame_err_count", 128'(ferr_seen), 128'(ferr_exp));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
